// File: rtl/tpsram_be.sv
// Two-port SRAM with per-byte write enables and a registered read path.
// Read latency of one or two edges; write-first or read-first on collision.
module tpsram_be #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5,
  parameter int RD_LAT  = 1,
  parameter int BYPASS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_wr_en,
  input  logic [BW_ADDR-1:0]   i_wr_addr,
  input  logic [BW_DATA-1:0]   i_wr_data,
  input  logic [BW_DATA/8-1:0] i_wr_be,
  input  logic                 i_rd_en,
  input  logic [BW_ADDR-1:0]   i_rd_addr,
  output logic [BW_DATA-1:0]   o_rd_data,
  output logic                 o_rd_valid
);

  localparam int NB    = BW_DATA / 8;
  localparam int DEPTH = 1 << BW_ADDR;

  logic [BW_DATA-1:0] r_mem [DEPTH];

  logic [BW_DATA-1:0] w_old;
  logic [BW_DATA-1:0] w_merge;
  logic [BW_DATA-1:0] w_rd_word;
  logic               w_hit;
  logic               w_st_vld;
  logic [BW_DATA-1:0] w_st_data;

  logic               r_vld;
  logic [BW_DATA-1:0] r_data;

  assign w_old = r_mem[i_rd_addr];

  assign w_hit = i_wr_en && i_rd_en &&
                 (i_wr_addr == i_rd_addr);

  // Old word overlaid with the bytes being written this edge.
  always_comb begin
    w_merge = w_old;
    for (int b = 0; b < NB; b++) begin
      if (i_wr_be[b]) begin
        w_merge[8*b +: 8] = i_wr_data[8*b +: 8];
      end
    end
  end

  assign w_rd_word = (BYPASS != 0 && w_hit) ? w_merge : w_old;

  // Byte-masked array write; array is never reset and is frozen in reset.
  always_ff @(posedge i_clk) begin
    if (i_rstn && i_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wr_be[b]) begin
          r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic               r_p1_vld;
      logic [BW_DATA-1:0] r_p1_data;

      // Extra pipeline stage between array and output register.
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          r_p1_vld  <= 1'b0;
          r_p1_data <= '0;
        end else begin
          r_p1_vld <= i_rd_en;
          if (i_rd_en) begin
            r_p1_data <= w_rd_word;
          end
        end
      end

      assign w_st_vld  = r_p1_vld;
      assign w_st_data = r_p1_data;
    end else begin : g_lat1
      assign w_st_vld  = i_rd_en;
      assign w_st_data = w_rd_word;
    end
  endgenerate

  // Output register: pulses valid per result, holds data otherwise.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= w_st_vld;
      if (w_st_vld) begin
        r_data <= w_st_data;
      end
    end
  end

  assign o_rd_data  = r_data;
  assign o_rd_valid = r_vld;

endmodule

// File: tb/tb_tpsram_be.sv
// Bench for tpsram_be: four instances cover both latencies and both
// collision policies, checked against a cycle-indexed behavioural model.
module tb_tpsram_be;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b1;
  logic        wen   = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe   = '0;
  logic        ren   = 1'b0;
  logic [4:0]  raddr = '0;

  logic [31:0] dd [4];
  logic        dv [4];

  always #5 clk = ~clk;

  tpsram_be #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(1), .BYPASS(1)) u0 (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wen), .i_wr_addr(waddr),
    .i_wr_data(wdata), .i_wr_be(wbe), .i_rd_en(ren), .i_rd_addr(raddr),
    .o_rd_data(dd[0]), .o_rd_valid(dv[0]));
  tpsram_be #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(1), .BYPASS(0)) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wen), .i_wr_addr(waddr),
    .i_wr_data(wdata), .i_wr_be(wbe), .i_rd_en(ren), .i_rd_addr(raddr),
    .o_rd_data(dd[1]), .o_rd_valid(dv[1]));
  tpsram_be #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(2), .BYPASS(1)) u2 (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wen), .i_wr_addr(waddr),
    .i_wr_data(wdata), .i_wr_be(wbe), .i_rd_en(ren), .i_rd_addr(raddr),
    .o_rd_data(dd[2]), .o_rd_valid(dv[2]));
  tpsram_be #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(2), .BYPASS(0)) u3 (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wen), .i_wr_addr(waddr),
    .i_wr_data(wdata), .i_wr_be(wbe), .i_rd_en(ren), .i_rd_addr(raddr),
    .o_rd_data(dd[3]), .o_rd_valid(dv[3]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] nw,
                                        logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Model: word array plus, per instance, the cycle in which each
  // result must appear (read at accepted edge N shows in cycle N+LAT-1).
  logic [31:0] mmem [32];
  bit          exp_v [4][4096];
  logic [31:0] exp_d [4][4096];
  int          cyc = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 3; j++) exp_v[k][cyc+j] = 1'b0;
    end else begin
      cyc++;
      if (ren) begin
        logic [31:0] old;
        logic [31:0] nw;
        old = mmem[raddr];
        nw  = (wen && waddr == raddr) ? merge(old, wdata, wbe) : old;
        for (int k = 0; k < 4; k++) begin
          int lat;
          lat = (k < 2) ? 1 : 2;
          exp_v[k][cyc+lat-1] = 1'b1;
          exp_d[k][cyc+lat-1] = (k % 2 == 0) ? nw : old;
        end
      end
      if (wen) mmem[waddr] = merge(mmem[waddr], wdata, wbe);
    end
  end

  bit          armed = 1'b0;
  logic [31:0] last_d [4];
  int          vc [4];

  initial begin
    for (int k = 0; k < 4; k++) begin
      last_d[k] = '0;
      vc[k] = 0;
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dv[k] === 1'b1) vc[k]++;
      if (armed) begin
        if (!rstn) last_d[k] = '0;
        chk($sformatf("u%0d.valid c%0d", k, cyc),
            {31'b0, dv[k]}, {31'b0, exp_v[k][cyc]});
        if (exp_v[k][cyc]) begin
          chk($sformatf("u%0d.data c%0d", k, cyc), dd[k], exp_d[k][cyc]);
          last_d[k] = exp_d[k][cyc];
        end else begin
          chk($sformatf("u%0d.hold c%0d", k, cyc), dd[k], last_d[k]);
        end
      end
    end
  end

  task automatic drive(bit we, int wa, logic [31:0] wd, logic [3:0] be,
                       bit re, int ra);
    wen   = we;
    waddr = 5'(wa);
    wdata = wd;
    wbe   = be;
    ren   = re;
    raddr = 5'(ra);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 4'h0, 0, 0);
  endtask

  int b0, b2;

  initial begin
    #2 rstn = 1'b0;
    armed = 1'b1;
    idle(2);
    chk("rst u0 data", dd[0], 32'h0);
    chk("rst u2 valid", {31'b0, dv[2]}, 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 32; i++) drive(1, i, 32'(i), 4'hF, 0, 0);

    b0 = vc[0];
    b2 = vc[2];
    drive(0, 0, 32'h0, 4'h0, 1, 0);
    chk("rb first u0 data", dd[0], 32'h0);
    chk("rb first u0 valid", {31'b0, dv[0]}, 32'h1);
    chk("rb first u2 valid", {31'b0, dv[2]}, 32'h0);
    for (int i = 1; i < 32; i++) drive(0, 0, 32'h0, 4'h0, 1, i);
    chk("rb last u0 data", dd[0], 32'd31);
    chk("rb last u2 data", dd[2], 32'd30);
    idle(2);
    chk("rb u0 pulses", 32'(vc[0] - b0), 32'd32);
    chk("rb u2 pulses", 32'(vc[2] - b2), 32'd32);

    drive(1, 3, 32'hAABBCCDD, 4'hF, 0, 0);
    drive(1, 3, 32'h11223344, 4'b0101, 0, 0);
    drive(0, 0, 32'h0, 4'h0, 1, 3);
    chk("be u0", dd[0], 32'hAA22CC44);
    idle(1);
    chk("be u2", dd[2], 32'hAA22CC44);

    drive(1, 4, 32'hFFFFFFFF, 4'h0, 0, 0);
    drive(0, 0, 32'h0, 4'h0, 1, 4);
    chk("be0 u0", dd[0], 32'd4);

    drive(1, 7, 32'h0, 4'hF, 0, 0);
    drive(1, 7, 32'hFFFF0000, 4'b1100, 1, 7);
    chk("col u0 wf", dd[0], 32'hFFFF0000);
    chk("col u1 rf", dd[1], 32'h0);
    drive(0, 0, 32'h0, 4'h0, 1, 7);
    chk("col2 u0", dd[0], 32'hFFFF0000);
    chk("col2 u1", dd[1], 32'hFFFF0000);
    chk("col u2 wf", dd[2], 32'hFFFF0000);
    chk("col u3 rf", dd[3], 32'h0);
    idle(1);
    chk("col2 u2", dd[2], 32'hFFFF0000);
    chk("col2 u3", dd[3], 32'hFFFF0000);

    b0 = vc[0];
    drive(0, 0, 32'h0, 4'h0, 1, 1);
    idle(5);
    chk("hold u0 data", dd[0], 32'd1);
    chk("hold u0 valid", {31'b0, dv[0]}, 32'h0);
    chk("hold u0 pulses", 32'(vc[0] - b0), 32'd1);

    b2 = vc[2];
    drive(0, 0, 32'h0, 4'h0, 1, 5);
    #2 rstn = 1'b0;
    #1;
    chk("arst u2 data", dd[2], 32'h0);
    chk("arst u2 valid", {31'b0, dv[2]}, 32'h0);
    chk("arst u0 data", dd[0], 32'h0);
    drive(1, 5, 32'hDEADBEEF, 4'hF, 1, 5);
    drive(1, 5, 32'hDEADBEEF, 4'hF, 1, 5);
    rstn = 1'b1;
    idle(3);
    chk("arst u2 pulses", 32'(vc[2] - b2), 32'h0);
    drive(0, 0, 32'h0, 4'h0, 1, 5);
    chk("arst keep u0", dd[0], 32'd5);
    idle(1);
    chk("arst keep u2", dd[2], 32'd5);

    drive(1, 31, 32'h1F1F1F1F, 4'hF, 0, 0);
    drive(1, 0, 32'hA0A0A0A0, 4'hF, 0, 0);
    drive(0, 0, 32'h0, 4'h0, 1, 31);
    chk("wrap u0 a31", dd[0], 32'h1F1F1F1F);
    drive(0, 0, 32'h0, 4'h0, 1, 0);
    chk("wrap u0 a0", dd[0], 32'hA0A0A0A0);
    chk("wrap u2 a31", dd[2], 32'h1F1F1F1F);
    idle(2);
    chk("wrap u2 a0", dd[2], 32'hA0A0A0A0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpsram_be.md
TPSRAM_BE -- requirements
Module: tpsram_be

Interface
REQ-001 The block SHALL expose parameter BW_DATA, default 32, read/write data width in bits; legal values are multiples of 8 in the range 8..128.
REQ-002 The block SHALL expose parameter BW_ADDR, default 5, address width; depth is 2**BW_ADDR words.
REQ-003 The block SHALL expose parameter RD_LAT, default 1, read latency in clock edges; legal values are 1 or 2.
REQ-004 The block SHALL expose parameter BYPASS, default 1; 1 selects write-first on an address collision, 0 selects read-first.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; the ports are i_clk and i_rstn.
REQ-006 i_clk  input  1  rising-edge clock for all state.
REQ-007 i_rstn  input  1  asynchronous active-low reset.
REQ-008 i_wr_en  input  1  write request, sampled at the rising edge.
REQ-009 i_wr_addr  input  BW_ADDR  write address.
REQ-010 i_wr_data  input  BW_DATA  write data.
REQ-011 i_wr_be  input  BW_DATA/8  byte enables; bit k covers data bits [8k+7:8k].
REQ-012 i_rd_en  input  1  read request, sampled at the rising edge.
REQ-013 i_rd_addr  input  BW_ADDR  read address.
REQ-014 o_rd_data  output  BW_DATA  read data, registered.
REQ-015 o_rd_valid  output  1  o_rd_data carries a fresh read result this cycle.

Function
REQ-016 The write port and the read port SHALL operate independently and concurrently in the same cycle.
REQ-017 At a rising edge with i_wr_en=1, the block SHALL update only the bytes of mem[i_wr_addr] whose i_wr_be bit is 1, and leave all other bytes unchanged.
REQ-018 A write with i_wr_en=1 and i_wr_be all zero SHALL leave the array unchanged.
REQ-019 A read sampled at edge N SHALL present its data on o_rd_data with o_rd_valid=1 after edge N+RD_LAT-1, i.e. during cycle N+RD_LAT.
REQ-020 o_rd_valid SHALL be 1 for exactly one cycle per accepted read, and 0 otherwise.
REQ-021 With RD_LAT=2, back-to-back reads on every cycle SHALL sustain one result per cycle, returned in issue order.
REQ-022 When no valid result emerges, o_rd_data SHALL hold its last value.
REQ-023 On a collision (i_wr_en=1, i_rd_en=1, i_wr_addr==i_rd_addr, same edge) with BYPASS=1, the read SHALL return the merged word: enabled bytes from i_wr_data and the remaining bytes from the old contents.
REQ-024 On a collision with BYPASS=0, the read SHALL return the pre-write contents, and the write SHALL still complete.
REQ-025 A read issued at the edge after a write to the same address SHALL return the written data, whatever the BYPASS setting.
REQ-026 Addresses SHALL wrap naturally at 2**BW_ADDR, with no out-of-range condition.
REQ-027 Array contents SHALL be undefined until written, and the bench SHALL NOT check unwritten locations.

Reset
REQ-028 While i_rstn=0, o_rd_data SHALL be 0, o_rd_valid SHALL be 0, and all read-pipeline stages SHALL be cleared.
REQ-029 Reset SHALL NOT clear the memory array, and the array SHALL retain its contents across reset.
REQ-030 Reads in flight when reset asserts SHALL be discarded and SHALL produce no o_rd_valid after reset release.
REQ-031 While i_rstn=0, writes and reads SHALL be ignored.
REQ-032 The first accepted request SHALL be the one at the first rising edge with i_rstn=1.

Verification
REQ-033 Fill and readback: write mem[i]=i for i=0..31 with be=4'hF, then read 0..31 back to back -> o_rd_data=i for each, with o_rd_valid high in cycles 1..32 after the first read edge (RD_LAT=1); repeat with RD_LAT=2 -> results shifted one cycle, none dropped.
REQ-034 Byte enable: write 32'hAABBCCDD to addr 3 with be=4'hF, then 32'h11223344 with be=4'b0101 -> read addr 3 returns 32'hAA22CC44.
REQ-035 Collision: mem[7]=32'h0, then write 32'hFFFF0000 with be=4'b1100 and read addr 7 at the same edge -> returns 32'hFFFF0000 with BYPASS=1 and 32'h0 with BYPASS=0; a following read of 7 returns 32'hFFFF0000 in both cases.
REQ-036 Reset mid-read: with RD_LAT=2, issue a read of addr 5, then assert i_rstn=0 before its data emerges -> o_rd_data=0 and o_rd_valid=0 immediately (asynchronously), no valid pulse after release, and a later read of 5 returns the pre-reset contents.
REQ-037 Hold: perform one read of addr 1 (value 1), then idle 5 cycles -> o_rd_valid pulses once, and o_rd_data stays 1 through the idle cycles.
REQ-038 Wrap: with BW_ADDR=5, write to addr 31 then to addr 0 -> both words read back correctly, with no aliasing.
